// File: rtl/sd_tx_fifo.sv
// Transmit FIFO for the SD data path: 32-bit words in, 4-bit nibbles out (MSB first).
// Define SD_TX_FIFO_UNDERRUN_EN to add the sticky underrun flag with its clr_err input.
module sd_tx_fifo #(
  parameter int DEPTH    = 8,
  parameter int ADR_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         d,
  input  logic                wr,
  output logic                full,
  output logic [3:0]          q,
  input  logic                rd,
  output logic                empty,
  output logic                word_start,
  output logic [ADR_SIZE-1:0] level,
`ifdef SD_TX_FIFO_UNDERRUN_EN
  output logic                underrun,
  input  logic                clr_err,
`endif
  input  logic                flush
);

  logic [ADR_SIZE-1:0] adr_in_q, adr_in_d;
  logic [ADR_SIZE-1:0] adr_out_q, adr_out_d;
  logic [2:0]          nib_cnt_q, nib_cnt_d;
  logic [31:0]         ram [DEPTH];
  logic [31:0]         rd_word;
  logic [4:0]          nib_lsb;
  logic                do_wr;
  logic                do_rd;

  // Flags come straight from the registered pointers; the MSB is the wrap bit.
  assign empty = (adr_in_q == adr_out_q);
  assign full  = (adr_in_q[ADR_SIZE-2:0] == adr_out_q[ADR_SIZE-2:0]) &&
                 (adr_in_q[ADR_SIZE-1] != adr_out_q[ADR_SIZE-1]);
  assign level = adr_in_q - adr_out_q;

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  // Nibble 0 sits at bits [31:28], so the LSB index is 4*(7-nib_cnt).
  assign rd_word    = ram[adr_out_q[ADR_SIZE-2:0]];
  assign nib_lsb    = {~nib_cnt_q, 2'b00};
  assign q          = empty ? 4'h0 : rd_word[nib_lsb +: 4];
  assign word_start = !empty && (nib_cnt_q == 3'd0);

  always_comb begin
    adr_in_d  = adr_in_q;
    adr_out_d = adr_out_q;
    nib_cnt_d = nib_cnt_q;
    if (flush) begin
      adr_in_d  = '0;
      adr_out_d = '0;
      nib_cnt_d = 3'd0;
    end else begin
      if (do_wr) begin
        adr_in_d = adr_in_q + 1'b1;
      end
      if (do_rd) begin
        nib_cnt_d = nib_cnt_q + 3'd1;
        if (nib_cnt_q == 3'd7) begin
          adr_out_d = adr_out_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_in_q  <= '0;
      adr_out_q <= '0;
      nib_cnt_q <= 3'd0;
    end else begin
      adr_in_q  <= adr_in_d;
      adr_out_q <= adr_out_d;
      nib_cnt_q <= nib_cnt_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) begin
      ram[adr_in_q[ADR_SIZE-2:0]] <= d;
    end
  end

`ifdef SD_TX_FIFO_UNDERRUN_EN
  logic underrun_q, underrun_d;

  // A new underrun event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    underrun_d = underrun_q;
    if (flush) begin
      underrun_d = 1'b0;
    end else if (rd && empty) begin
      underrun_d = 1'b1;
    end else if (clr_err) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_sd_tx_fifo.sv
// Bench for sd_tx_fifo: fixed vector table, directed corner sequences and random traffic
// checked against a word-queue reference model.
module tb_sd_tx_fifo;

  localparam int DEPTH    = 8;
  localparam int ADR_SIZE = 4;

  logic                clk;
  logic                rst_n;
  logic [31:0]         d;
  logic                wr;
  logic                full;
  logic [3:0]          q;
  logic                rd;
  logic                empty;
  logic                word_start;
  logic [ADR_SIZE-1:0] level;
  logic                flush;
  logic                clr_err;
  logic                underrun;

  sd_tx_fifo #(.DEPTH(DEPTH), .ADR_SIZE(ADR_SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .wr         (wr),
    .full       (full),
    .q          (q),
    .rd         (rd),
    .empty      (empty),
    .word_start (word_start),
    .level      (level),
`ifdef SD_TX_FIFO_UNDERRUN_EN
    .underrun   (underrun),
    .clr_err    (clr_err),
`endif
    .flush      (flush)
  );

`ifndef SD_TX_FIFO_UNDERRUN_EN
  assign underrun = 1'b0;
`endif

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: queue of stored words plus index of the next nibble of the head word.
  logic [31:0] exp_q[$];
  int          m_nib;
  logic        m_under;

  function automatic logic [3:0] model_q();
    if (exp_q.size() == 0) return 4'h0;
    return 4'((exp_q[0] >> (28 - 4 * m_nib)) & 32'hF);
  endfunction

  task automatic model_step(input logic w, input logic [31:0] wd, input logic r,
                            input logic f, input logic c);
    bit can_wr, can_rd, was_empty;
    was_empty = (exp_q.size() == 0);
    can_wr = (exp_q.size() < DEPTH);
    can_rd = !was_empty;
    if (f) begin
      exp_q.delete();
      m_nib   = 0;
      m_under = 1'b0;
    end else begin
      if (r && was_empty) m_under = 1'b1;
      else if (c)         m_under = 1'b0;
      if (can_rd && r) begin
        m_nib++;
        if (m_nib == 8) begin
          void'(exp_q.pop_front());
          m_nib = 0;
        end
      end
      if (can_wr && w) exp_q.push_back(wd);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},          32'(q),          32'(model_q()));
    check({tag, ".empty"},      32'(empty),      32'(exp_q.size() == 0));
    check({tag, ".full"},       32'(full),       32'(exp_q.size() == DEPTH));
    check({tag, ".level"},      32'(level),      32'(exp_q.size()));
    check({tag, ".word_start"}, 32'(word_start), 32'(exp_q.size() != 0 && m_nib == 0));
`ifdef SD_TX_FIFO_UNDERRUN_EN
    check({tag, ".underrun"},   32'(underrun),   32'(m_under));
`endif
  endtask

  // Driver: one clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cycle(input logic w, input logic [31:0] wd, input logic r,
                       input logic f, input logic c);
    @(negedge clk);
    wr = w; d = wd; rd = r; flush = f; clr_err = c;
    model_step(w, wd, r, f, c);
    @(posedge clk);
    #1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] d;
    logic        rd;
    logic [3:0]  eq;
    logic        eempty;
    logic [3:0]  elevel;
    logic        ews;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] w0;
    logic [31:0] wv;
    n_vec = 0; n_err = 0; m_nib = 0; m_under = 1'b0;
    wr = 0; d = '0; rd = 0; flush = 0; clr_err = 0;
    rst_n = 1'b0;

    // Table: one word written, then all eight nibbles read.
    w0 = 32'h1234ABCD;
    tbl[0] = '{1'b1, w0, 1'b0, 4'h1, 1'b0, 4'd1, 1'b1};
    for (int k = 1; k <= 8; k++) begin
      tbl[k].wr     = 1'b0;
      tbl[k].d      = '0;
      tbl[k].rd     = 1'b1;
      tbl[k].eq     = (k < 8) ? 4'((w0 >> (28 - 4 * k)) & 32'hF) : 4'h0;
      tbl[k].eempty = (k == 8);
      tbl[k].elevel = (k < 8) ? 4'd1 : 4'd0;
      tbl[k].ews    = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.full", 32'(full), 32'd0);
    check("reset.level", 32'(level), 32'd0);
    check("reset.q", 32'(q), 32'd0);
    check("reset.word_start", 32'(word_start), 32'd0);
`ifdef SD_TX_FIFO_UNDERRUN_EN
    check("reset.underrun", 32'(underrun), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wr = tbl[i].wr; d = tbl[i].d; rd = tbl[i].rd; flush = 1'b0; clr_err = 1'b0;
      model_step(tbl[i].wr, tbl[i].d, tbl[i].rd, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d.q", i), 32'(q), 32'(tbl[i].eq));
      check($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].eempty));
      check($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].elevel));
      check($sformatf("tbl%0d.word_start", i), 32'(word_start), 32'(tbl[i].ews));
    end
    @(negedge clk);
    wr = 0; rd = 0;

    // Fill to full, reject a ninth write, drain all 64 nibbles (wraps both pointers).
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      check_model("fill");
    end
    check("fill.full", 32'(full), 32'd1);
    check("fill.level", 32'(level), 32'd8);
    cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    check_model("fill_reject");
    for (int i = 0; i < 8 * DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_model("drain");
    end
    check("drain.empty", 32'(empty), 32'd1);

    // Full FIFO: write alongside the final-nibble read is still rejected.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h55AA55AA, 1'b1, 1'b0, 1'b0);
    check("fullrd.full", 32'(full), 32'd0);
    check("fullrd.level", 32'(level), 32'd7);
    check_model("fullrd");
    cycle(1'b1, 32'h600DBEEF, 1'b0, 1'b0, 1'b0);
    check("fullrd_next.level", 32'(level), 32'd8);
    check_model("fullrd_next");

    // Empty FIFO: read alongside a write is ignored.
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_model("flush_empty");
    cycle(1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    check("emptywr.q", 32'(q), 32'hC);
    check("emptywr.word_start", 32'(word_start), 32'd1);
    check_model("emptywr");

    // Flush after a partial word.
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_model("prefl");
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("flush.empty", 32'(empty), 32'd1);
    check("flush.level", 32'(level), 32'd0);
    check("flush.q", 32'(q), 32'd0);
    check("flush.word_start", 32'(word_start), 32'd0);
    cycle(1'b1, 32'h9876FEDC, 1'b0, 1'b0, 1'b0);
    check("postflush.q", 32'(q), 32'h9);
    check("postflush.word_start", 32'(word_start), 32'd1);

`ifdef SD_TX_FIFO_UNDERRUN_EN
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("under.set", 32'(underrun), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("under.hold", 32'(underrun), 32'd1);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("under.clr", 32'(underrun), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("under.set_wins", 32'(underrun), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("under.flush", 32'(underrun), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic w, r, f, c;
      w = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 70);
      f = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 19) == 0);
      cycle(w, $urandom, r, f, c);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_tx_fifo.md
Name: sd_tx_fifo

Overview:
- Transmit-direction data FIFO for the SD controller data path.
- Accepts 32-bit words from the host/DMA side and delivers them as a 4-bit nibble stream to the SD data-line serializer, one nibble per read strobe.
- Single clock domain. Word-wide storage with wrap-bit pointers.
- Reports full, empty and word fill level.

Parameters:
- DEPTH, 8, number of 32-bit words stored; must be a power of 2.
- ADR_SIZE, 4, pointer width = log2(DEPTH)+1; MSB is the wrap bit.

Ports:
- clk  input  1  FIFO clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  32  write data word.
- wr  input  1  write strobe, one word per cycle.
- full  output  1  no free word slot.
- q  output  4  current nibble to transmit.
- rd  input  1  nibble read strobe; consumes q.
- empty  output  1  no unconsumed word present.
- word_start  output  1  q is nibble 0 of a word; high when nib_cnt==0 and !empty.
- level  output  ADR_SIZE  words present, including a partially consumed word.
- flush  input  1  synchronous clear of FIFO contents.

Behaviour:
- Reset (rst_n low, async):
  - adr_i=0, adr_o=0, nib_cnt (3-bit)=0.
  - Outputs: empty=1, full=0, level=0, q=0, word_start=0.
  - RAM contents are not reset.
- Storage: ram[DEPTH] x 32, indexed by pointer bits [ADR_SIZE-2:0].
- Write:
  - If wr & !full: ram[adr_i low] <= d and adr_i increments.
  - Increment wraps the low bits to 0 and toggles the wrap bit.
  - wr while full is ignored: no pointer change, no RAM write.
- Nibble output:
  - q is combinational: nibble nib_cnt of ram[adr_o low], MSB first.
  - nib_cnt=0 selects d[31:28]; nib_cnt=7 selects d[3:0].
  - q=4'h0 whenever empty=1.
- Read:
  - If rd & !empty: nib_cnt increments.
  - When nib_cnt==7: nib_cnt returns to 0 and adr_o increments, with the same wrap rule as adr_i.
  - rd while empty is ignored.
- Flags (all computed from registered pointers):
  - empty = (adr_i == adr_o).
  - full = (low bits equal) & (wrap bits differ).
  - level = adr_i - adr_o, modulo 2^ADR_SIZE; range 0..DEPTH.
- Simultaneous wr and rd: both act independently in the same cycle.
  - wr while full is still rejected, even if the same-cycle rd pops the last nibble of a word.
  - rd while empty is still rejected, even if wr is writing that cycle.
  - A written word becomes readable on the next cycle. Write-to-q latency is 1 clock.
- Flush (synchronous, highest priority over wr/rd):
  - adr_i, adr_o and nib_cnt go to 0 on that edge.
  - empty=1 the following cycle.
- Partial word consumption: level and empty count the word as present until its 8th nibble is read.

Optional Feature:
- Macro: SD_TX_FIFO_UNDERRUN_EN.
- Defined:
  - Adds output underrun (1 bit) and input clr_err (1 bit).
  - underrun sets sticky on any cycle with rd & empty.
  - clr_err clears it synchronously. A set in the same cycle wins over the clear.
  - underrun resets to 0 on rst_n low and on flush.
- Not defined: these ports and the logic behind them are absent. rd while empty is silently ignored.

Test Plan:
- Reset then write 0x1234ABCD, then 8 rd pulses:
  - q sequence is 1,2,3,4,A,B,C,D.
  - word_start=1 only before the first nibble.
  - empty=1 after the 8th rd; level goes 1 -> 0.
- Fill DEPTH=8 words without reads:
  - full=1, level=8.
  - A 9th wr with d=0xFFFFFFFF is ignored.
  - Reading out all 64 nibbles returns the original 8 words in order, and wrap bits toggle.
- Full FIFO, with wr asserted in the same cycle as the 8th-nibble rd:
  - The write is rejected; full deasserts next cycle.
  - A wr on the following cycle is accepted.
- Empty FIFO, with wr 0xCAFEF00D and rd in the same cycle:
  - The rd is ignored; next cycle q=4'hC and nib_cnt=0.
- Write 3 words, read 5 nibbles, then assert flush:
  - Next cycle empty=1, level=0, q=0, nib_cnt=0.
  - A subsequent word reads from nibble 0.
- With SD_TX_FIFO_UNDERRUN_EN:
  - rd while empty sets underrun=1, which holds for 10 cycles.
  - clr_err clears it; simultaneous rd&empty and clr_err leaves underrun=1.
